cmult_arbiter: RTL

CMULT_ARBITER -- requirements
Module: cmult_arbiter

---
 rtl/cmult_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cmult_arbiter.sv
// Two-requester round-robin front end for a shared registered complex multiplier.
// One operation in flight: IDLE -> ISSUE -> CAPT -> RESP, result held until the consumer takes it.
module cmult_arbiter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ReqValid0,
    input  logic                   ReqValid1,
    input  logic [15:0]            ReqOpA0,
    input  logic [15:0]            ReqOpA1,
    input  logic [15:0]            ReqOpB0,
    input  logic [15:0]            ReqOpB1,
    output logic                   ReqReady0,
    output logic                   ReqReady1,
    output logic [15:0]            MulIn1,
    output logic [15:0]            MulIn2,
    input  logic [33:0]            MulResult,
    output logic                   RespValid,
    output logic                   RespId,
    output logic [33:0]            RespData,
    input  logic                   RespReady,
    output logic                   Busy,
    output logic [COUNT_WIDTH-1:0] OpCount
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_RESP
    } state_t;

    state_t                   state_q;
    logic                     rr_q;
    logic [15:0]              mul_in1_q;
    logic [15:0]              mul_in2_q;
    logic                     resp_valid_q;
    logic                     resp_id_q;
    logic [33:0]              resp_data_q;
    logic                     busy_q;
    logic [COUNT_WIDTH-1:0]   op_count_q;

    logic                     grant_valid;
    logic                     grant_id;
    logic [1:0]               req_ready;
    logic [15:0]              op_a_d;
    logic [15:0]              op_b_d;
    logic [COUNT_WIDTH-1:0]   op_count_d;

    // rr_q names the requester that wins when both are pending.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ReqValid0 && ReqValid1) begin
                grant_valid = 1'b1;
                grant_id    = rr_q;
            end else if (ReqValid0) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (ReqValid1) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready[gi] = grant_valid && (grant_id == 1'(gi));
    end

    assign op_a_d     = grant_id ? ReqOpA1 : ReqOpA0;
    assign op_b_d     = grant_id ? ReqOpB1 : ReqOpB0;
    assign op_count_d = op_count_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            mul_in1_q    <= '0;
            mul_in2_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mul_in1_q <= op_a_d;
                        mul_in2_q <= op_b_d;
                        resp_id_q <= grant_id;
                        rr_q      <= ~grant_id;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    // Multiplier output reflects operands registered two edges ago.
                    resp_data_q  <= MulResult;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (RespReady) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        op_count_q   <= op_count_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqReady0 = req_ready[0];
    assign ReqReady1 = req_ready[1];
    assign MulIn1    = mul_in1_q;
    assign MulIn2    = mul_in2_q;
    assign RespValid = resp_valid_q;
    assign RespId    = resp_id_q;
    assign RespData  = resp_data_q;
    assign Busy      = busy_q;
    assign OpCount   = op_count_q;

endmodule
